// File: rtl/run_length_reporter_pkg.sv
// Shared types and default sizing for the run-length reporter.
// Other files pull these in with a wildcard import of this package.
package run_length_reporter_pkg;

    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned DEPTH_DEF = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rlr_state_e;

endpackage

// File: rtl/run_length_reporter_if.sv
// Report stream between the run-length reporter (master) and its consumer (slave).
// The head entry is presented while rpt_valid is high and taken when rpt_ready is also high.
interface run_length_reporter_if
    import run_length_reporter_pkg::*;
    #(parameter int unsigned LEN_W = LEN_W_DEF) ();

    logic             rpt_valid;
    logic             rpt_ready;
    logic [LEN_W-1:0] rpt_len;
    logic             rpt_sat;

    modport master (output rpt_valid, output rpt_len, output rpt_sat, input rpt_ready);
    modport slave  (input rpt_valid, input rpt_len, input rpt_sat, output rpt_ready);

endinterface

// File: rtl/run_length_reporter_fifo.sv
// Report FIFO with a registered head. A write to an empty FIFO shows up one cycle later.
// When the FIFO is full, a write is dropped unless a pop happens in the same cycle.
module rlr_fifo
    import run_length_reporter_pkg::*;
    #(
        parameter int unsigned WIDTH = LEN_W_DEF + 1,
        parameter int unsigned DEPTH = DEPTH_DEF
    ) (
        input  logic             clk,
        input  logic             rst,
        input  logic             wr_en,
        input  logic [WIDTH-1:0] wr_data,
        input  logic             rd_en,
        output logic             rd_valid,
        output logic [WIDTH-1:0] rd_data,
        output logic             drop
    );

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;
    localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(DEPTH);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_FW-1:0] count_r;
    logic              valid_r;
    logic [WIDTH-1:0]  data_r;

    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [CNT_FW-1:0] count_nxt_s;
    logic [WIDTH-1:0]  head_nxt_s;

    // Next-state occupancy and next head value; the head register is loaded from here.
    always_comb begin
        full_s       = (count_r == FULL_CNT);
        pop_s        = rd_en & valid_r;
        push_s       = wr_en & (~full_s | pop_s);
        drop         = wr_en & full_s & ~pop_s;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = '0;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_FW'(1);
            2'b01:   count_nxt_s = count_r - CNT_FW'(1);
            default: count_nxt_s = count_r;
        endcase
        // The new head may be the very entry being written this cycle.
        if (count_nxt_s == CNT_FW'(0)) begin
            head_nxt_s = '0;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage, pointers and the registered head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r    <= '{default: '0};
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            data_r   <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            valid_r  <= (count_nxt_s != CNT_FW'(0));
            data_r   <= head_nxt_s;
        end
    end

    assign rd_valid = valid_r;
    assign rd_data  = data_r;

endmodule

// File: rtl/run_length_reporter.sv
// Measures runs of det_in=1 and queues one {length, saturated} report per finished run.
// It also counts the runs that have started and keeps a sticky flag for reports lost to a full FIFO.
module run_length_reporter
    import run_length_reporter_pkg::*;
    #(
        parameter int unsigned LEN_W = LEN_W_DEF,
        parameter int unsigned CNT_W = CNT_W_DEF,
        parameter int unsigned DEPTH = DEPTH_DEF
    ) (
        input  logic                   clk,
        input  logic                   rst,
        input  logic                   det_in,
        run_length_reporter_if.master  rpt,
        output logic [CNT_W-1:0]       event_count,
        output logic                   overflow
    );

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    rlr_state_e       state_r;
    logic [LEN_W-1:0] len_r;
    logic             sat_r;
    logic [CNT_W-1:0] ev_cnt_r;
    logic             ovf_r;
    logic             wr_en_s;
    logic             drop_s;
    logic [LEN_W:0]   head_s;

    assign wr_en_s = (state_r == RUN) & ~det_in;

    // Episode FSM, which also holds the run-length, start-count and sticky-overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            len_r    <= '0;
            sat_r    <= 1'b0;
            ev_cnt_r <= '0;
            ovf_r    <= 1'b0;
        end else begin
            ovf_r <= ovf_r | drop_s;
            case (state_r)
                IDLE: begin
                    if (det_in) begin
                        state_r  <= RUN;
                        len_r    <= LEN_W'(1);
                        sat_r    <= 1'b0;
                        ev_cnt_r <= ev_cnt_r + CNT_W'(1);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (!det_in) begin
                        state_r <= IDLE;
                        len_r   <= '0;
                    end else if (len_r == LEN_MAX) begin
                        sat_r <= 1'b1;
                    end else begin
                        len_r <= len_r + LEN_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    len_r   <= '0;
                    sat_r   <= 1'b0;
                end
            endcase
        end
    end

    rlr_fifo #(
        .WIDTH (LEN_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .wr_data  ({len_r, sat_r}),
        .rd_en    (rpt.rpt_ready),
        .rd_valid (rpt.rpt_valid),
        .rd_data  (head_s),
        .drop     (drop_s)
    );

    assign rpt.rpt_len  = head_s[LEN_W:1];
    assign rpt.rpt_sat  = head_s[0];
    assign event_count  = ev_cnt_r;
    assign overflow     = ovf_r;

endmodule

// File: doc/run_length_reporter.md
RUN_LENGTH_REPORTER -- requirements
Module: run_length_reporter

Interface
REQ-001 Parameter LEN_W, default 8, width of the run-length field.
REQ-002 Parameter CNT_W, default 16, width of the episode counter.
REQ-003 Parameter DEPTH, default 4, report FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 det_in  input  1  registered detect level from the upstream sequence-detector FSM; synchronous to clk.
REQ-007 rpt_valid  output  1  report FIFO non-empty; head entry presented.
REQ-008 rpt_ready  input  1  consumer accepts the head entry.
REQ-009 rpt_len  output  LEN_W  length of the head episode in clk cycles.
REQ-010 rpt_sat  output  1  head episode length saturated.
REQ-011 event_count  output  CNT_W  number of episodes started since reset.
REQ-012 overflow  output  1  sticky; at least one report was dropped because the FIFO was full.

Function
REQ-013 An episode SHALL be a maximal run of consecutive cycles with det_in=1.
REQ-014 The FSM SHALL have two states: IDLE and RUN.
REQ-015 IDLE with det_in=1: go to RUN, set run length to 1, clear the saturation flag, increment event_count.
REQ-016 IDLE with det_in=0: stay in IDLE, no other action.
REQ-017 RUN with det_in=1: stay in RUN and increment the run length.
REQ-018 Run-length saturation: the run length stops at 2^LEN_W-1 and the saturation flag is set once the count would exceed that value.
REQ-019 RUN with det_in=0: go to IDLE and write {length, saturation flag} to the FIFO in the same cycle.
REQ-020 A new episode starting on the cycle immediately after a termination SHALL be counted normally; the minimum gap is one cycle.
REQ-021 Write latency: an entry written in cycle N SHALL appear on rpt_valid/rpt_len in cycle N+1; there is no combinational fall-through.
REQ-022 Pop condition: rpt_valid & rpt_ready pops the head entry at the clock edge.
REQ-023 While rpt_valid=1 and rpt_ready=0, rpt_len and rpt_sat SHALL hold stable.
REQ-024 Write when full and no pop in the same cycle: the entry is dropped, overflow is set, and the FIFO contents are unchanged.
REQ-025 Write and pop in the same cycle: both SHALL be performed, including when the FIFO is full; the occupancy is unchanged and there is no overflow.
REQ-026 event_count SHALL wrap modulo 2^CNT_W.
REQ-027 overflow SHALL clear only on reset.
REQ-028 rpt_ready SHALL be ignored while rpt_valid=0.

Reset
REQ-029 When rst=0, asynchronously: state IDLE, run length 0, FIFO empty, event_count 0, overflow 0.
REQ-030 Output values during reset: rpt_valid=0, rpt_len=0, rpt_sat=0.
REQ-031 Reset asserted mid-episode SHALL discard the partial run; no report is produced for it.
REQ-032 Reset release with det_in=1: the first posedge after release starts a new episode from IDLE.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE, RUN) and the default LEN_W, CNT_W and DEPTH constants.
REQ-034 The FIFO SHALL be a separate sub-module, rlr_fifo: synchronous, registered output, parameterised on width and DEPTH, with the same clk and rst.
REQ-035 The top level SHALL contain only the FSM, the counters and the FIFO instance.

Verification
REQ-036 Single episode, FIFO empty: det_in high for 3 cycles then low, rpt_ready=1 -> exactly one report, rpt_len=3, rpt_sat=0, event_count=1.
REQ-037 Saturation, LEN_W=8: det_in high for 300 cycles -> one report, rpt_len=255, rpt_sat=1.
REQ-038 Back-to-back episodes, rpt_ready=0: det_in pattern 1,1,0,1,0 -> two entries in order, rpt_len=2 then 1; event_count=2; head held stable while rpt_ready=0.
REQ-039 Overflow, DEPTH=4, rpt_ready=0: five 1-cycle episodes -> 4 entries kept, overflow=1, fifth report lost; then with rpt_ready=1 exactly 4 pops occur.
REQ-040 Full FIFO, push and pop in the same cycle: an episode terminates in the pop cycle -> overflow stays 0 and the new entry is last in order.
REQ-041 Reset mid-episode: det_in high for 5 cycles, rst pulsed low in cycle 3 -> no report for that run, all outputs 0, event_count=1 after the next episode starts.
